nx_ctrl_host: RTL

NX_CTRL_HOST -- requirements
Module: nx_ctrl_host

---
 rtl/nx_ctrl_host.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/nx_ctrl_host.sv
// Host-side controller front end: turns host commands into controller requests and
// decodes controller responses (output-frame reassembly, status, mesh messages, run tracking).
package nx_ctrl_host_pkg;
  localparam int TIMER_WIDTH      = 16;
  localparam int OUT_BITS_PER_MSG = 40;
  localparam int MAX_COLUMNS      = 16;

  localparam logic [1:0] OP_RUN         = 2'd0;
  localparam logic [1:0] OP_STOP        = 2'd1;
  localparam logic [1:0] OP_READ_STATUS = 2'd2;
  localparam logic [1:0] OP_SOFT_RESET  = 2'd3;

  localparam logic [1:0] CMD_TRIGGER     = 2'd0;
  localparam logic [1:0] CMD_READ_STATUS = 2'd1;
  localparam logic [1:0] CMD_SOFT_RESET  = 2'd2;

  localparam logic [2:0] FMT_OUTPUTS   = 3'd0;
  localparam logic [2:0] FMT_STATUS    = 3'd1;
  localparam logic [2:0] FMT_FROM_MESH = 3'd2;
  localparam logic [2:0] FMT_PARAMS    = 3'd3;

  typedef struct packed {
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] payload;
  } node_message_t;

  typedef struct packed {
    logic [1:0]             command;
    logic [MAX_COLUMNS-1:0] col_mask;
    logic [TIMER_WIDTH-1:0] cycles;
    logic                   active;
  } control_request_t;

  typedef struct packed {
    logic [2:0]                  format;
    logic [7:0]                  index;
    logic [TIMER_WIDTH-1:0]      stamp;
    logic [OUT_BITS_PER_MSG-1:0] section;
    logic                        active;
    logic [TIMER_WIDTH-1:0]      cycle;
    node_message_t               message;
  } control_response_t;
endpackage

module nx_ctrl_host
  import nx_ctrl_host_pkg::*;
#(
  parameter int COLUMNS = 3,
  parameter int OUTPUTS = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic [1:0]                        i_cmd_op,
  input  logic [TIMER_WIDTH-1:0]            i_cmd_cycles,
  input  logic [COLUMNS-1:0]                i_cmd_col_mask,
  output control_request_t                  o_ctrl_in_data,
  output logic                              o_ctrl_in_valid,
  input  logic                              i_ctrl_in_ready,
  input  control_response_t                 i_ctrl_out_data,
  input  logic                              i_ctrl_out_valid,
  output logic                              o_ctrl_out_ready,
  output logic [COLUMNS*OUTPUTS-1:0]        o_out_data,
  output logic [TIMER_WIDTH-1:0]            o_out_stamp,
  output logic                              o_out_valid,
  output logic                              o_status_valid,
  output logic                              o_status_active,
  output logic [TIMER_WIDTH-1:0]            o_status_cycle,
  output node_message_t                     o_mesh_msg,
  output logic                              o_mesh_msg_valid,
  output logic                              o_busy,
  output logic                              o_run_done,
  output logic                              o_err_seq
);
  localparam int MESH_OUTPUTS = COLUMNS * OUTPUTS;
  localparam int NUM_MSGS     = (MESH_OUTPUTS + OUT_BITS_PER_MSG - 1) / OUT_BITS_PER_MSG;
  localparam int BUF_W        = NUM_MSGS * OUT_BITS_PER_MSG;

  control_request_t       req_next;
  logic                   accept;
  logic                   is_out, idx_match, idx_zero, stamp_ok;
  logic                   store, seq_err, last;
  logic [7:0]             exp_idx;
  logic [TIMER_WIDTH-1:0] frame_stamp, cur_stamp, remaining;
  logic [BUF_W-1:0]       frame_buf, sec_buf;

  assign o_cmd_ready      = !o_ctrl_in_valid;
  assign o_ctrl_out_ready = 1'b1;
  assign accept           = i_cmd_valid && o_cmd_ready;

  always_comb begin
    req_next = '0;
    unique case (i_cmd_op)
      OP_RUN: begin
        req_next.command              = CMD_TRIGGER;
        req_next.col_mask[COLUMNS-1:0] = i_cmd_col_mask;
        req_next.cycles               = i_cmd_cycles;
        req_next.active               = 1'b1;
      end
      OP_STOP:        req_next.command = CMD_TRIGGER;
      OP_READ_STATUS: req_next.command = CMD_READ_STATUS;
      default:        req_next.command = CMD_SOFT_RESET;
    endcase
  end

  // A section is kept when it continues the current frame with a matching stamp,
  // or when it is index 0 (which always opens a fresh frame).
  assign is_out    = i_ctrl_out_valid && (i_ctrl_out_data.format == FMT_OUTPUTS);
  assign idx_match = (i_ctrl_out_data.index == exp_idx);
  assign idx_zero  = (i_ctrl_out_data.index == 8'd0);
  assign stamp_ok  = idx_zero || (i_ctrl_out_data.stamp == frame_stamp);
  assign store     = is_out && (idx_match ? stamp_ok : idx_zero);
  assign seq_err   = is_out && !(idx_match && stamp_ok);
  assign last      = store && (i_ctrl_out_data.index == 8'(NUM_MSGS - 1));
  assign cur_stamp = idx_zero ? i_ctrl_out_data.stamp : frame_stamp;

  always_comb begin
    sec_buf = idx_zero ? '0 : frame_buf;
    for (int m = 0; m < NUM_MSGS; m++) begin
      if (i_ctrl_out_data.index == 8'(m))
        sec_buf[m*OUT_BITS_PER_MSG +: OUT_BITS_PER_MSG] = i_ctrl_out_data.section;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ctrl_in_data   <= '0;
      o_ctrl_in_valid  <= 1'b0;
      o_out_data       <= '0;
      o_out_stamp      <= '0;
      o_out_valid      <= 1'b0;
      o_status_valid   <= 1'b0;
      o_status_active  <= 1'b0;
      o_status_cycle   <= '0;
      o_mesh_msg       <= '0;
      o_mesh_msg_valid <= 1'b0;
      o_busy           <= 1'b0;
      o_run_done       <= 1'b0;
      o_err_seq        <= 1'b0;
      exp_idx          <= '0;
      frame_stamp      <= '0;
      frame_buf        <= '0;
      remaining        <= '0;
    end else begin
      o_out_valid      <= 1'b0;
      o_status_valid   <= 1'b0;
      o_mesh_msg_valid <= 1'b0;
      o_run_done       <= 1'b0;

      if (o_ctrl_in_valid && i_ctrl_in_ready)
        o_ctrl_in_valid <= 1'b0;

      if (seq_err)
        o_err_seq <= 1'b1;

      if (store) begin
        if (last) begin
          o_out_data  <= sec_buf[MESH_OUTPUTS-1:0];
          o_out_stamp <= cur_stamp;
          o_out_valid <= 1'b1;
          exp_idx     <= '0;
          if (remaining > TIMER_WIDTH'(1)) begin
            remaining <= remaining - TIMER_WIDTH'(1);
          end else if (remaining == TIMER_WIDTH'(1)) begin
            remaining  <= '0;
            o_busy     <= 1'b0;
            o_run_done <= 1'b1;
          end
        end else begin
          exp_idx     <= i_ctrl_out_data.index + 8'd1;
          frame_buf   <= sec_buf;
          frame_stamp <= cur_stamp;
        end
      end else if (seq_err) begin
        exp_idx <= '0;
      end

      if (i_ctrl_out_valid && i_ctrl_out_data.format == FMT_STATUS) begin
        o_status_active <= i_ctrl_out_data.active;
        o_status_cycle  <= i_ctrl_out_data.cycle;
        o_status_valid  <= 1'b1;
      end
      if (i_ctrl_out_valid && i_ctrl_out_data.format == FMT_FROM_MESH) begin
        o_mesh_msg       <= i_ctrl_out_data.message;
        o_mesh_msg_valid <= 1'b1;
      end

      // Command effects come last so they override a same-cycle frame completion.
      if (accept) begin
        o_ctrl_in_data  <= req_next;
        o_ctrl_in_valid <= 1'b1;
        unique case (i_cmd_op)
          OP_RUN: begin
            o_busy     <= 1'b1;
            remaining  <= i_cmd_cycles;
            o_run_done <= 1'b0;
          end
          OP_STOP: begin
            o_busy     <= 1'b0;
            remaining  <= '0;
            o_run_done <= 1'b0;
          end
          OP_SOFT_RESET: begin
            o_busy     <= 1'b0;
            remaining  <= '0;
            o_run_done <= 1'b0;
            o_err_seq  <= 1'b0;
            exp_idx    <= '0;
            frame_buf  <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
